// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA definitions for the fetch front-end: instruction field layout, opcodes,
// FSM state type and the illegal-opcode helper.
package instr_fetch_unit_pkg;

  localparam int unsigned InstrW = 16;
  localparam int unsigned OpMsb  = 15;
  localparam int unsigned OpLsb  = 13;
  localparam int unsigned ImmW   = 7;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpAddi = 3'b001;
  localparam logic [2:0] OpSub  = 3'b010;
  localparam logic [2:0] OpLw   = 3'b011;
  localparam logic [2:0] OpSw   = 3'b100;
  localparam logic [2:0] OpBeq  = 3'b101;
  localparam logic [2:0] OpIllegalMask = 3'b110;

  typedef enum logic [0:0] {StRun, StHalt} fetch_state_e;

  // Opcodes 110 and 111 are unassigned and stop the fetch stream.
  function automatic logic is_illegal(logic [2:0] op);
    return (op & OpIllegalMask) == OpIllegalMask;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch bus: instruction-memory read port plus the valid/ready link to decode.
interface instr_fetch_unit_if import instr_fetch_unit_pkg::*; #(
  parameter int unsigned PcW = 8
) ();

  logic              imem_en;
  logic [PcW-1:0]    imem_addr;
  logic [InstrW-1:0] imem_rdata;
  logic [InstrW-1:0] instr;
  logic [2:0]        opcode;
  logic [PcW-1:0]    instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              branch_taken;
  logic              halted;

  modport master (
    output imem_en, imem_addr, instr, opcode, instr_pc, instr_valid, halted,
    input  imem_rdata, instr_ready, branch_taken
  );

  modport slave (
    input  imem_en, imem_addr, instr, opcode, instr_pc, instr_valid, halted,
    output imem_rdata, instr_ready, branch_taken
  );

endinterface

// File: rtl/instr_fetch_unit_skid.sv
// One-entry skid buffer holding a returned instruction word and its PC while the
// output register is stalled. Clear has priority; push overrides a same-cycle pop.
module instr_fetch_unit_skid import instr_fetch_unit_pkg::*; #(
  parameter int unsigned PcW = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [InstrW-1:0] data_i,
  input  logic [PcW-1:0]    pc_i,
  output logic              valid_o,
  output logic [InstrW-1:0] data_o,
  output logic [PcW-1:0]    pc_o
);

  logic              valid_q, valid_d;
  logic [InstrW-1:0] data_q, data_d;
  logic [PcW-1:0]    pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-issue in-order fetch: PC, 1-cycle imem request tracking, output register plus
// skid, taken-beq redirect and sticky halt on an illegal opcode.
module instr_fetch_unit import instr_fetch_unit_pkg::*; #(
  parameter int unsigned PcW = 8
) (
  input logic clk_i,
  input logic rst_ni,
  instr_fetch_unit_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [PcW-1:0]    fpc_q, fpc_d;
  logic [InstrW-1:0] ir_q, ir_d;
  logic [PcW-1:0]    ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              pending_q, pending_d;
  logic [PcW-1:0]    pend_pc_q, pend_pc_d;

  logic              skid_valid, skid_push, skid_pop, skid_clr;
  logic [InstrW-1:0] skid_data;
  logic [PcW-1:0]    skid_pc;

  logic              imem_en, transfer, flush, ir_free, halt_evt;
  logic [InstrW-1:0] load_word;
  logic [PcW-1:0]    load_pc, br_target;
  logic [31:0]       imm_sext;

  instr_fetch_unit_skid #(.PcW(PcW)) u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (skid_clr),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .data_i  (bus.imem_rdata),
    .pc_i    (pend_pc_q),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .pc_o    (skid_pc)
  );

  assign transfer  = ir_valid_q & bus.instr_ready;
  assign flush     = transfer & (ir_q[OpMsb:OpLsb] == OpBeq) & bus.branch_taken;
  assign ir_free   = ~ir_valid_q | transfer;
  // The skid always holds the oldest word, so it drains before any fresh return.
  assign load_word = skid_valid ? skid_data : bus.imem_rdata;
  assign load_pc   = skid_valid ? skid_pc : pend_pc_q;
  assign imm_sext  = {{(32 - ImmW){ir_q[ImmW-1]}}, ir_q[ImmW-1:0]};
  assign br_target = PcW'(32'(ir_pc_q) + 32'd1 + imm_sext);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (halt_evt) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  // Reset gates the request so the port is quiet while held in reset.
  always_comb begin
    imem_en = 1'b0;
    unique case (state_q)
      StRun:   imem_en = rst_ni & ~skid_valid &
                         ~(pending_q & ir_valid_q & ~bus.instr_ready);
      StHalt:  imem_en = 1'b0;
      default: imem_en = 1'b0;
    endcase
  end

  always_comb begin
    fpc_d      = fpc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q & ~transfer;
    pending_d  = imem_en;
    pend_pc_d  = fpc_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_clr   = 1'b0;
    halt_evt   = 1'b0;
    if (imem_en) fpc_d = fpc_q + PcW'(1);
    if (flush) begin
      fpc_d     = br_target;
      pending_d = 1'b0;
      skid_clr  = 1'b1;
    end else if (state_q == StRun) begin
      if (ir_free && (skid_valid || pending_q)) begin
        if (is_illegal(load_word[OpMsb:OpLsb])) begin
          halt_evt  = 1'b1;
          pending_d = 1'b0;
          skid_clr  = 1'b1;
        end else begin
          ir_d       = load_word;
          ir_pc_d    = load_pc;
          ir_valid_d = 1'b1;
          skid_pop   = skid_valid;
          skid_push  = skid_valid & pending_q;
        end
      end else if (pending_q) begin
        skid_push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fpc_q      <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      pending_q  <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      fpc_q      <= fpc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      pending_q  <= pending_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign bus.imem_en     = imem_en;
  assign bus.imem_addr   = fpc_q;
  assign bus.instr       = ir_q;
  assign bus.opcode      = ir_q[OpMsb:OpLsb];
  assign bus.instr_pc    = ir_pc_q;
  assign bus.instr_valid = ir_valid_q;
  assign bus.halted      = (state_q == StHalt);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: program-order PCs are queued as stimulus is set
// up and popped on every decode transfer; a second instance covers 4-bit PC wrap.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.PcW(8)) ifc ();
  instr_fetch_unit_if #(.PcW(4)) ifc4 ();

  instr_fetch_unit #(.PcW(8)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(ifc));
  instr_fetch_unit #(.PcW(4)) dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(ifc4));

  logic [15:0] mem [256];
  logic [15:0] mem4 [16];
  int checks = 0;
  int failures = 0;
  int q[$];
  int q4[$];

  always @(posedge clk) if (ifc.imem_en) ifc.imem_rdata <= mem[ifc.imem_addr];
  always @(posedge clk) if (ifc4.imem_en) ifc4.imem_rdata <= mem4[ifc4.imem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int e;
    if (rst_n && ifc.instr_valid && ifc.instr_ready && q.size() > 0) begin
      e = q.pop_front();
      chk("seq_pc", 32'(ifc.instr_pc), e);
      chk("seq_instr", 32'(ifc.instr), 32'(mem[e]));
      chk("seq_opcode", 32'(ifc.opcode), 32'(mem[e][15:13]));
    end
  end

  always @(negedge clk) begin
    int e;
    if (rst_n && ifc4.instr_valid && ifc4.instr_ready && q4.size() > 0) begin
      e = q4.pop_front();
      chk("wrap_pc", 32'(ifc4.instr_pc), e);
      chk("wrap_instr", 32'(ifc4.instr), 32'(mem4[e]));
    end
  end

  task automatic init_mem();
    for (int a = 0; a < 256; a++) mem[a] = {3'b000, 5'd0, 8'(a)};
    for (int a = 0; a < 16; a++) mem4[a] = {3'b001, 9'd0, 4'(a)};
  endtask

  // Reset both instances and release on a falling edge.
  task automatic start();
    rst_n = 1'b0;
    q.delete();
    q4.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) q.push_back(i);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 32'(q.size()), 0);
  endtask

  initial begin
    int n;
    ifc.instr_ready = 1'b1;
    ifc.branch_taken = 1'b0;
    ifc4.instr_ready = 1'b1;
    ifc4.branch_taken = 1'b0;
    init_mem();

    // Reset values and fill latency
    @(negedge clk);
    chk("rst_en", 32'(ifc.imem_en), 0);
    chk("rst_addr", 32'(ifc.imem_addr), 0);
    chk("rst_valid", 32'(ifc.instr_valid), 0);
    chk("rst_instr", 32'(ifc.instr), 0);
    chk("rst_pc", 32'(ifc.instr_pc), 0);
    chk("rst_halted", 32'(ifc.halted), 0);
    start();
    #1;
    chk("first_en", 32'(ifc.imem_en), 1);
    chk("first_addr", 32'(ifc.imem_addr), 0);
    push_range(0, 9);
    edge_n(1);
    chk("lat_edge1_valid", 32'(ifc.instr_valid), 0);
    edge_n(1);
    chk("lat_edge2_valid", 32'(ifc.instr_valid), 1);
    chk("lat_edge2_pc", 32'(ifc.instr_pc), 0);
    edge_n(3);
    chk("steady_pc", 32'(ifc.instr_pc), 3);
    wait_empty(40);

    // Decode stall at PC 4
    start();
    push_range(0, 9);
    edge_n(6);
    ifc.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_valid", 32'(ifc.instr_valid), 1);
      chk("stall_pc", 32'(ifc.instr_pc), 4);
      chk("stall_instr", 32'(ifc.instr), 32'(mem[4]));
      chk("stall_en", 32'(ifc.imem_en), 0);
      edge_n(1);
    end
    ifc.instr_ready = 1'b1;
    #1;
    chk("release_en_skid", 32'(ifc.imem_en), 0);
    wait_empty(40);

    // Taken beq at PC 10 with imm7 = -5
    mem[10] = {3'b101, 6'd0, 7'h7B};
    start();
    ifc.branch_taken = 1'b1;
    push_range(0, 10);
    push_range(6, 8);
    edge_n(12);
    chk("beq_pc", 32'(ifc.instr_pc), 10);
    edge_n(1);
    chk("flush_valid1", 32'(ifc.instr_valid), 0);
    edge_n(1);
    chk("flush_valid2", 32'(ifc.instr_valid), 0);
    edge_n(1);
    chk("target_valid", 32'(ifc.instr_valid), 1);
    chk("target_pc", 32'(ifc.instr_pc), 6);
    wait_empty(60);

    // Same beq not taken
    start();
    ifc.branch_taken = 1'b0;
    push_range(0, 14);
    wait_empty(40);
    mem[10] = {3'b000, 5'd0, 8'd10};

    // PC wrap on the 4-bit instance
    start();
    for (int i = 0; i < 16; i++) q4.push_back(i);
    for (int i = 0; i < 3; i++) q4.push_back(i);
    n = 0;
    while (q4.size() > 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("wrap_drain", 32'(q4.size()), 0);

    // Illegal opcode at PC 3
    mem[3] = 16'hC000;
    start();
    push_range(0, 2);
    wait_empty(20);
    edge_n(2);
    for (int i = 0; i < 4; i++) begin
      chk("halt_flag", 32'(ifc.halted), 1);
      chk("halt_valid", 32'(ifc.instr_valid), 0);
      chk("halt_en", 32'(ifc.imem_en), 0);
      edge_n(1);
    end

    // Taken beq at PC 2 back to 0 squashes the illegal word
    mem[2] = {3'b101, 6'd0, 7'h7D};
    start();
    ifc.branch_taken = 1'b1;
    push_range(0, 2);
    push_range(0, 2);
    push_range(0, 0);
    wait_empty(40);
    chk("nohalt_flag", 32'(ifc.halted), 0);
    ifc.branch_taken = 1'b0;
    mem[2] = {3'b000, 5'd0, 8'd2};
    mem[3] = {3'b000, 5'd0, 8'd3};

    // Reset mid-stream with a request outstanding
    start();
    edge_n(6);
    chk("mid_pending_valid", 32'(ifc.instr_valid), 1);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_en", 32'(ifc.imem_en), 0);
    chk("mid_rst_valid", 32'(ifc.instr_valid), 0);
    chk("mid_rst_pc", 32'(ifc.instr_pc), 0);
    chk("mid_rst_addr", 32'(ifc.imem_addr), 0);
    chk("mid_rst_instr", 32'(ifc.instr), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_range(0, 2);
    edge_n(1);
    chk("restart_edge1_valid", 32'(ifc.instr_valid), 0);
    edge_n(1);
    chk("restart_pc", 32'(ifc.instr_pc), 0);
    wait_empty(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
